// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and types for the 1:4 stream demux
package stream_demux_pkg;
  localparam int N_CH = 4;
  localparam int SEL_W = 2;
  localparam int FIFO_DEPTH = 2;
  typedef logic [1:0] cnt_t;
endpackage

// File: rtl/stream_demux_fifo2.sv
// stream_demux_fifo2: 2-entry synchronous FIFO with registered head and status
module stream_demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  cnt_t cnt;
  logic wp, rp;
  logic [DATA_W-1:0] mem [2];
  logic do_push, do_pop;
  assign full = cnt == cnt_t'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end
endmodule

// File: rtl/stream_demux4.sv
// stream_demux4: registered 1:4 stream demux with per-channel 2-deep FIFOs
module stream_demux4
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        ch_full
);
  logic [N_CH-1:0] full, empty, push;
  assign in_ready = rst_n && !full[in_sel];
  assign out_valid = ~empty;
  assign ch_full = full;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign push[i] = in_valid && in_ready && in_sel == SEL_W'(i);
    stream_demux_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .push(push[i]),
      .pop(out_ready[i]),
      .din(in_data),
      .full(full[i]),
      .empty(empty[i]),
      .head(out_data[i*DATA_W +: DATA_W])
    );
  end
endmodule
